// File: rtl/enemy_shots_if.sv
// Bus between the enemy-shot block and the rest of the game: enemy pose and
// hit flags in, packed shot positions and launch status out.
interface enemy_shots_if;
  logic        play;
  logic [9:0]  enemy_x;
  logic [9:0]  enemy_y;
  logic [4:0]  destroy;
  logic [45:0] proj_x;
  logic [44:0] proj_y;
  logic [4:0]  active;
  logic        fire_pulse;
  logic [7:0]  shots_fired;

  modport master (
    output play, enemy_x, enemy_y, destroy,
    input  proj_x, proj_y, active, fire_pulse, shots_fired
  );

  modport slave (
    input  play, enemy_x, enemy_y, destroy,
    output proj_x, proj_y, active, fire_pulse, shots_fired
  );
endinterface

// File: rtl/enemy_shots.sv
// Enemy shot launcher: a STOP/COUNT/LAUNCH timer drops a shot below the enemy
// every FIRE_INTERVAL+1 ticks into the lowest free of five slots; live shots
// fall by SPEED per tick and retire at FLOOR_Y or when the player hits them.
// Slot y is held in 9 bits because a live shot is always below FLOOR_Y (< 512);
// all y arithmetic is done wider so a step past 511 cannot wrap.
module enemy_shots #(
  parameter int FIRE_INTERVAL = 60,
  parameter int SPEED         = 2,
  parameter int FLOOR_Y       = 470,
  parameter int DROP_OFFSET   = 10
) (
  input  logic         clk_4,
  input  logic         clr,
  enemy_shots_if.slave bus
);

  localparam logic [7:0]  LP_RELOAD = 8'(FIRE_INTERVAL - 1);
  localparam logic [10:0] LP_SPEED  = 11'(SPEED);
  localparam logic [10:0] LP_FLOOR  = 11'(FLOOR_Y);
  localparam logic [10:0] LP_DROP   = 11'(DROP_OFFSET);

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_COUNT  = 2'd1,
    ST_LAUNCH = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_n;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_n;

  logic [45:0] r_px;
  logic [45:0] w_px_n;
  logic [8:0]  r_y   [5];
  logic [8:0]  w_y_n [5];
  logic [4:0]  r_act;
  logic [4:0]  w_act_n;
  logic        r_pulse;
  logic [7:0]  r_shots;

  logic [10:0] w_step [5];
  logic [4:0]  w_clear;
  logic [4:0]  w_free;
  logic [4:0]  w_sel_oh;
  logic [4:0]  w_load;
  logic [10:0] w_spawn_y;
  logic [8:0]  w_sat_x;
  logic        w_launch;

  // Per-slot next y after one fall step, and whether the slot goes idle this tick.
  for (genvar k = 0; k < 5; k++) begin : g_slot
    assign w_step[k]  = {2'b00, r_y[k]} + LP_SPEED;
    assign w_clear[k] = !bus.play ||
                        (r_act[k] && (bus.destroy[k] || (w_step[k] >= LP_FLOOR)));
  end

  // Lowest free slot as a one-hot (isolate lowest set bit of the free mask).
  // A hit on the chosen slot cancels the launch rather than re-targeting it.
  assign w_free    = ~r_act;
  assign w_sel_oh  = w_free & (~w_free + 5'd1);
  assign w_spawn_y = {1'b0, bus.enemy_y} + LP_DROP;
  assign w_launch  = (r_state == ST_LAUNCH) && bus.play && (|w_free) &&
                     (w_spawn_y < LP_FLOOR) && !(|(w_sel_oh & bus.destroy));
  assign w_load    = w_launch ? w_sel_oh : 5'd0;
  assign w_sat_x   = (bus.enemy_x > 10'd511) ? 9'd511 : bus.enemy_x[8:0];

  // Launch timer next-state: halting always returns to STOP.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    if (!bus.play) begin
      w_state_n = ST_STOP;
      w_cnt_n   = LP_RELOAD;
    end else begin
      case (r_state)
        ST_STOP: begin
          w_state_n = ST_COUNT;
          w_cnt_n   = LP_RELOAD;
        end
        ST_COUNT: begin
          if (r_cnt == 8'd0) begin
            w_state_n = ST_LAUNCH;
          end else begin
            w_cnt_n = r_cnt - 8'd1;
          end
        end
        ST_LAUNCH: begin
          w_state_n = ST_COUNT;
          w_cnt_n   = LP_RELOAD;
        end
        default: begin
          w_state_n = ST_STOP;
          w_cnt_n   = LP_RELOAD;
        end
      endcase
    end
  end

  // Slot next values: clear beats launch beats movement; idle slots stay zero.
  always_comb begin
    w_px_n  = r_px;
    w_act_n = r_act;
    for (int k = 0; k < 5; k++) begin
      w_y_n[k] = r_y[k];
    end
    for (int k = 0; k < 5; k++) begin
      if (w_clear[k]) begin
        w_act_n[k] = 1'b0;
        w_y_n[k]   = 9'd0;
      end else if (w_load[k]) begin
        w_act_n[k] = 1'b1;
        w_y_n[k]   = w_spawn_y[8:0];
      end else if (r_act[k]) begin
        w_y_n[k]   = w_step[k][8:0];
      end else begin
        w_y_n[k]   = r_y[k];
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (w_clear[k]) begin
        w_px_n[9*k +: 9] = 9'd0;
      end else if (w_load[k]) begin
        w_px_n[9*k +: 9] = w_sat_x;
      end else begin
        w_px_n[9*k +: 9] = r_px[9*k +: 9];
      end
    end
    if (w_clear[4]) begin
      w_px_n[45:36] = 10'd0;
    end else if (w_load[4]) begin
      w_px_n[45:36] = bus.enemy_x;
    end else begin
      w_px_n[45:36] = r_px[45:36];
    end
  end

  // Timer state register.
  always_ff @(posedge clk_4) begin
    if (clr) begin
      r_state <= ST_STOP;
      r_cnt   <= LP_RELOAD;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
    end
  end

  // Slot, strobe and launch-count registers.
  always_ff @(posedge clk_4) begin
    if (clr) begin
      r_px    <= 46'd0;
      r_act   <= 5'd0;
      r_pulse <= 1'b0;
      r_shots <= 8'd0;
      for (int k = 0; k < 5; k++) begin
        r_y[k] <= 9'd0;
      end
    end else begin
      r_px    <= w_px_n;
      r_act   <= w_act_n;
      r_pulse <= w_launch;
      r_shots <= r_shots + (w_launch ? 8'd1 : 8'd0);
      for (int k = 0; k < 5; k++) begin
        r_y[k] <= w_y_n[k];
      end
    end
  end

  assign bus.proj_x      = r_px;
  assign bus.proj_y      = {r_y[4], r_y[3], r_y[2], r_y[1], r_y[0]};
  assign bus.active      = r_act;
  assign bus.fire_pulse  = r_pulse;
  assign bus.shots_fired = r_shots;

endmodule

// File: tb/tb_enemy_shots.sv
// Bench for enemy_shots: two instances (FIRE_INTERVAL 60 and 2) share one
// stimulus stream and are compared every tick against a slot-level model.
module tb_enemy_shots;

  localparam int SPEED = 2;
  localparam int FLOOR = 470;
  localparam int DROP  = 10;

  logic       clk_4 = 1'b0;
  logic       clr;
  logic       t_play;
  logic [9:0] t_ex;
  logic [9:0] t_ey;
  logic [4:0] t_destroy;

  int errors = 0;
  int checks = 0;

  always #5 clk_4 = ~clk_4;

  enemy_shots_if if0 ();
  enemy_shots_if if1 ();

  assign if0.play    = t_play;
  assign if0.enemy_x = t_ex;
  assign if0.enemy_y = t_ey;
  assign if0.destroy = t_destroy;
  assign if1.play    = t_play;
  assign if1.enemy_x = t_ex;
  assign if1.enemy_y = t_ey;
  assign if1.destroy = t_destroy;

  enemy_shots #(.FIRE_INTERVAL(60)) dut0 (.clk_4(clk_4), .clr(clr), .bus(if0.slave));
  enemy_shots #(.FIRE_INTERVAL(2))  dut1 (.clk_4(clk_4), .clr(clr), .bus(if1.slave));

  logic [104:0] dut_vec [2];
  assign dut_vec[0] = {if0.proj_x, if0.proj_y, if0.active, if0.fire_pulse, if0.shots_fired};
  assign dut_vec[1] = {if1.proj_x, if1.proj_y, if1.active, if1.fire_pulse, if1.shots_fired};

  // Reference model: slot contents plus ticks elapsed since play was first seen.
  bit m_live  [2][5];
  int m_x     [2][5];
  int m_y     [2][5];
  bit m_run   [2];
  int m_ticks [2];
  int m_shots [2];
  bit m_pulse [2];

  function automatic int fi_of(int inst);
    return (inst == 0) ? 60 : 2;
  endfunction

  task automatic model_clear_slots(int inst);
    for (int k = 0; k < 5; k++) begin
      m_live[inst][k] = 1'b0;
      m_x[inst][k]    = 0;
      m_y[inst][k]    = 0;
    end
  endtask

  task automatic model_step(int inst);
    int sel;
    int spawn;
    m_pulse[inst] = 1'b0;
    if (clr) begin
      model_clear_slots(inst);
      m_run[inst]   = 1'b0;
      m_shots[inst] = 0;
      return;
    end
    if (!t_play) begin
      model_clear_slots(inst);
      m_run[inst] = 1'b0;
      return;
    end
    if (!m_run[inst]) begin
      m_run[inst]   = 1'b1;
      m_ticks[inst] = 0;
      return;
    end
    m_ticks[inst]++;
    sel = -1;
    for (int k = 4; k >= 0; k--) if (!m_live[inst][k]) sel = k;
    for (int k = 0; k < 5; k++) begin
      if (m_live[inst][k]) begin
        m_y[inst][k] += SPEED;
        if (t_destroy[k] || m_y[inst][k] >= FLOOR) begin
          m_live[inst][k] = 1'b0;
          m_x[inst][k]    = 0;
          m_y[inst][k]    = 0;
        end
      end
    end
    spawn = int'(t_ey) + DROP;
    if ((m_ticks[inst] % (fi_of(inst) + 1)) == 0 && sel >= 0 && spawn < FLOOR && !t_destroy[sel]) begin
      m_live[inst][sel] = 1'b1;
      m_x[inst][sel]    = (sel < 4 && t_ex > 10'd511) ? 511 : int'(t_ex);
      m_y[inst][sel]    = spawn;
      m_pulse[inst]     = 1'b1;
      m_shots[inst]     = (m_shots[inst] + 1) % 256;
    end
  endtask

  function automatic logic [104:0] exp_vec(int inst);
    logic [45:0] px;
    logic [44:0] py;
    logic [4:0]  act;
    px  = '0;
    py  = '0;
    act = '0;
    for (int k = 0; k < 4; k++) px[9*k +: 9] = 9'(m_x[inst][k]);
    px[45:36] = 10'(m_x[inst][4]);
    for (int k = 0; k < 5; k++) begin
      py[9*k +: 9] = 9'(m_y[inst][k]);
      act[k]       = m_live[inst][k];
    end
    return {px, py, act, m_pulse[inst], 8'(m_shots[inst])};
  endfunction

  task automatic tick();
    @(posedge clk_4);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic do_reset();
    clr       = 1'b1;
    t_play    = 1'b0;
    t_destroy = 5'd0;
    tick();
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    clr       = 1'b1;
    t_play    = 1'b1;
    t_destroy = 5'h1f;
    t_ex      = 10'd300;
    t_ey      = 10'd100;
    repeat (3) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dut_vec[i] !== 105'd0) begin
          errors++;
          $display("FAIL reset inst%0d got %h want 0", i, dut_vec[i]);
        end
      end
    end
    clr       = 1'b0;
    t_play    = 1'b0;
    t_destroy = 5'd0;
    tick();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dut_vec[i] !== exp_vec(i)) begin
        errors++;
        $display("FAIL reset_idle inst%0d got %h want %h", i, dut_vec[i], exp_vec(i));
      end
    end
  endtask

  task automatic test_first_launch();
    int n_seen;
    do_reset();
    t_ex   = 10'd320;
    t_ey   = 10'd100;
    t_play = 1'b1;
    n_seen = -1;
    for (int n = 0; n < 200; n++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dut_vec[i] !== exp_vec(i)) begin
          errors++;
          $display("FAIL first_launch inst%0d got %h want %h", i, dut_vec[i], exp_vec(i));
        end
      end
      if (if0.fire_pulse === 1'b1) begin
        n_seen = n;
        break;
      end
    end
    checks++;
    if (n_seen !== 61) begin
      errors++;
      $display("FAIL first_launch_latency got %0d want 61", n_seen);
    end
    checks++;
    if ({if0.proj_x[8:0], if0.proj_y[8:0], if0.active} !== {9'd320, 9'd110, 5'b00001}) begin
      errors++;
      $display("FAIL first_launch_slot0 got x=%0d y=%0d act=%b want x=320 y=110 act=00001",
               if0.proj_x[8:0], if0.proj_y[8:0], if0.active);
    end
  endtask

  task automatic test_flight_retire();
    int prev;
    int n;
    prev = int'(if0.proj_y[8:0]);
    n    = 0;
    for (int j = 0; j < 300; j++) begin
      tick();
      n++;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dut_vec[i] !== exp_vec(i)) begin
          errors++;
          $display("FAIL flight inst%0d got %h want %h", i, dut_vec[i], exp_vec(i));
        end
      end
      if (if0.active[0] !== 1'b1) break;
      checks++;
      if (int'(if0.proj_y[8:0]) != prev + SPEED) begin
        errors++;
        $display("FAIL flight_step got %0d want %0d", if0.proj_y[8:0], prev + SPEED);
      end
      prev = int'(if0.proj_y[8:0]);
    end
    checks++;
    if (n != 180 || if0.proj_y[8:0] !== 9'd0) begin
      errors++;
      $display("FAIL retire got ticks=%0d y=%0d want ticks=180 y=0", n, if0.proj_y[8:0]);
    end
  endtask

  task automatic test_slots_full();
    do_reset();
    t_ex   = 10'd100;
    t_ey   = 10'd100;
    t_play = 1'b1;
    for (int j = 0; j < 100; j++) begin
      tick();
      checks++;
      if (dut_vec[1] !== exp_vec(1)) begin
        errors++;
        $display("FAIL slots_fill got %h want %h", dut_vec[1], exp_vec(1));
      end
      if (if1.active === 5'h1f) break;
    end
    checks++;
    if (if1.shots_fired !== 8'd5 || if1.active !== 5'h1f) begin
      errors++;
      $display("FAIL slots_full got shots=%0d act=%b want shots=5 act=11111", if1.shots_fired, if1.active);
    end
    repeat (4) begin
      tick();
      checks++;
      if ({if1.fire_pulse, if1.shots_fired, if1.active} !== {1'b0, 8'd5, 5'h1f}) begin
        errors++;
        $display("FAIL full_skip got pulse=%b shots=%0d act=%b want pulse=0 shots=5 act=11111",
                 if1.fire_pulse, if1.shots_fired, if1.active);
      end
    end
  endtask

  task automatic test_destroy();
    logic [44:0] prev_y;
    logic [45:0] prev_x;
    logic [4:0]  prev_act;
    do_reset();
    t_ex   = 10'd200;
    t_ey   = 10'd100;
    t_play = 1'b1;
    for (int j = 0; j < 150; j++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dut_vec[i] !== exp_vec(i)) begin
          errors++;
          $display("FAIL destroy_setup inst%0d got %h want %h", i, dut_vec[i], exp_vec(i));
        end
      end
      if (if1.active[2] === 1'b1 && if1.proj_y[26:18] === 9'd200) break;
    end
    prev_y    = if1.proj_y;
    prev_x    = if1.proj_x;
    prev_act  = if1.active;
    t_destroy = 5'b00100;
    tick();
    t_destroy = 5'd0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (dut_vec[i] !== exp_vec(i)) begin
        errors++;
        $display("FAIL destroy inst%0d got %h want %h", i, dut_vec[i], exp_vec(i));
      end
    end
    checks++;
    if ({if1.active[2], if1.proj_y[26:18], if1.proj_x[26:18]} !== {1'b0, 9'd0, 9'd0}) begin
      errors++;
      $display("FAIL destroy_slot2 got act=%b y=%0d x=%0d want 0 0 0",
               if1.active[2], if1.proj_y[26:18], if1.proj_x[26:18]);
    end
    for (int k = 0; k < 5; k++) begin
      if (k != 2) begin
        checks++;
        if (int'(if1.proj_y[9*k +: 9]) != int'(prev_y[9*k +: 9]) + SPEED ||
            if1.proj_x[9*k +: 9] !== prev_x[9*k +: 9] || if1.active[k] !== prev_act[k]) begin
          errors++;
          $display("FAIL destroy_other slot%0d got y=%0d act=%b want y=%0d act=%b",
                   k, if1.proj_y[9*k +: 9], if1.active[k], prev_y[9*k +: 9] + 9'd2, prev_act[k]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    t_ex   = 10'd600;
    t_ey   = 10'd100;
    t_play = 1'b1;
    for (int j = 0; j < 100; j++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dut_vec[i] !== exp_vec(i)) begin
          errors++;
          $display("FAIL saturation inst%0d got %h want %h", i, dut_vec[i], exp_vec(i));
        end
      end
      if (if0.fire_pulse === 1'b1) break;
    end
    checks++;
    if ({if1.proj_x[8:0], if1.proj_x[45:36], if0.proj_x[8:0]} !== {9'd511, 10'd600, 9'd511}) begin
      errors++;
      $display("FAIL saturation_lanes got s0=%0d s4=%0d d0s0=%0d want 511 600 511",
               if1.proj_x[8:0], if1.proj_x[45:36], if0.proj_x[8:0]);
    end
  endtask

  task automatic test_play_drop();
    int n_seen;
    do_reset();
    t_ex   = 10'd50;
    t_ey   = 10'd50;
    t_play = 1'b1;
    for (int j = 0; j < 100; j++) begin
      tick();
      if (if1.active === 5'b00111) break;
    end
    checks++;
    if (if1.shots_fired !== 8'd3 || dut_vec[1] !== exp_vec(1)) begin
      errors++;
      $display("FAIL drop_setup got %h want %h", dut_vec[1], exp_vec(1));
    end
    t_play = 1'b0;
    tick();
    checks++;
    if ({if1.proj_x, if1.proj_y, if1.active, if1.shots_fired} !== {46'd0, 45'd0, 5'd0, 8'd3}) begin
      errors++;
      $display("FAIL play_drop got x=%h y=%h act=%b shots=%0d want 0 0 0 3",
               if1.proj_x, if1.proj_y, if1.active, if1.shots_fired);
    end
    t_play = 1'b1;
    n_seen = -1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (if1.fire_pulse === 1'b1) begin
        n_seen = n;
        break;
      end
    end
    checks++;
    if (n_seen != 3 || if1.shots_fired !== 8'd4) begin
      errors++;
      $display("FAIL restart_from_stop got n=%0d shots=%0d want n=3 shots=4", n_seen, if1.shots_fired);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int j = 0; j < 1500; j++) begin
      t_ex      = 10'($urandom_range(0, 1023));
      t_ey      = 10'($urandom_range(0, 480));
      t_destroy = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
      t_play    = ($urandom_range(0, 99) != 0);
      clr       = ($urandom_range(0, 499) == 0);
      tick();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (dut_vec[i] !== exp_vec(i)) begin
          errors++;
          $display("FAIL random inst%0d step %0d got %h want %h", i, j, dut_vec[i], exp_vec(i));
        end
      end
    end
    clr = 1'b0;
  endtask

  initial begin
    clr       = 1'b1;
    t_play    = 1'b0;
    t_ex      = 10'd0;
    t_ey      = 10'd0;
    t_destroy = 5'd0;
    test_reset();
    test_first_launch();
    test_flight_retire();
    test_slots_full();
    test_destroy();
    test_saturation();
    test_play_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
